pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register: the successor to the fixed EXE/MEM latch. It carries a control bundle and a data bundle between any two CPU stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It adds a valid/ready handshake, back-pressure, synchronous flush to a NOP bubble, an optional skid buffer, and a saturating stall-cycle counter. One instance is placed per stage boundary; hazard logic drives `flush`, and the downstream stage drives `out_ready`.

---
 rtl/pipe_pkg.sv | 51 +++++
 rtl/pipe_stage_reg_sat_counter.sv | 27 ++
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline registers.
//   - control field widths (RAM enable/op, WB data select, reg-write op)
//   - data field widths (IH, PC, ALU result, store data, WB address)
//   - named NOP control constants, one per stage boundary
//   - pack_ctrl helper that concatenates the control fields in bus order
// Every NOP constant deasserts all write/enable fields, so a bubble can never
// write memory or the register file.
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Control field widths
    localparam int RAM_EN_W     = 1;
    localparam int RAM_OP_W     = 2;
    localparam int WB_DATA_OP_W = 2;
    localparam int REG_OP_W     = 3;
    localparam int CTRL_BUS_W   = RAM_EN_W + RAM_OP_W + WB_DATA_OP_W + REG_OP_W;

    // Data field widths
    localparam int IH_W       = 24;
    localparam int PC_W       = 16;
    localparam int ALU_W      = 16;
    localparam int STORE_W    = 16;
    localparam int WB_ADDR_W  = 8;
    localparam int DATA_BUS_W = IH_W + PC_W + ALU_W + STORE_W + WB_ADDR_W;

    // Field order on the bus, MSB first: ram_en, ram_op, wb_data_op, reg_op
    typedef struct packed {
        logic [RAM_EN_W-1:0]     ram_en;
        logic [RAM_OP_W-1:0]     ram_op;
        logic [WB_DATA_OP_W-1:0] wb_data_op;
        logic [REG_OP_W-1:0]     reg_op;
    } ctrl_t;

    function automatic logic [CTRL_BUS_W-1:0] pack_ctrl(
        input logic [RAM_EN_W-1:0]     ram_en,
        input logic [RAM_OP_W-1:0]     ram_op,
        input logic [WB_DATA_OP_W-1:0] wb_data_op,
        input logic [REG_OP_W-1:0]     reg_op
    );
        return {ram_en, ram_op, wb_data_op, reg_op};
    endfunction

    // NOP control per boundary: no RAM access, no register write
    localparam ctrl_t CTRL_NOP_IF_ID   = '{ram_en: '0, ram_op: '0, wb_data_op: '0, reg_op: '0};
    localparam ctrl_t CTRL_NOP_ID_EXE  = '{ram_en: '0, ram_op: '0, wb_data_op: '0, reg_op: '0};
    localparam ctrl_t CTRL_NOP_EXE_MEM = '{ram_en: '0, ram_op: '0, wb_data_op: '0, reg_op: '0};
    localparam ctrl_t CTRL_NOP_MEM_WB  = '{ram_en: '0, ram_op: '0, wb_data_op: '0, reg_op: '0};

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the stall-cycle statistic.
// Ports:
//   clk  - clock, rising edge
//   clr  - synchronous clear, highest priority
//   inc  - count one this cycle
//   cnt  - current count; sticks at all-ones, never wraps
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised inter-stage pipeline register with valid/ready handshake,
// back-pressure, synchronous flush to a NOP bubble and a saturating
// stall-cycle counter.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   - a second (skid) entry is added; in_ready is a registered
//               "skid empty" flag with no path from out_ready.
//   undefined - single entry; in_ready = out_ready || !out_valid.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   flush               - synchronous kill of all held contents
//   in_valid/in_ready   - upstream handshake, in_ctrl/in_data payload
//   out_valid/out_ready - downstream handshake, out_ctrl/out_data payload
//   stall_cnt           - saturating count of cycles out_valid && !out_ready
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The sender keeps valid and payload stable until that edge;
// valid never depends on ready. Priority per cycle: rst > flush > transfer.
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 CTRL_W      = CTRL_BUS_W,
    parameter int                 DATA_W      = DATA_BUS_W,
    parameter logic [CTRL_W-1:0]  NOP_CTRL    = CTRL_W'(CTRL_NOP_EXE_MEM),
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              accept;
    logic              emit;

    assign accept    = in_valid && in_ready;
    assign emit      = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Registered ready: only the skid occupancy decides acceptance.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        // rst and flush empty both entries identically; only the stall
        // counter distinguishes them.
        if (rst || flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= NOP_CTRL;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= NOP_CTRL;
            skid_data  <= '0;
        end else if (accept && main_valid && !out_ready) begin
            // Main is blocked: park the new entry behind it.
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end else if (accept) begin
            // Accept implies the skid is empty, so main is the next entry.
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
        end else if (emit) begin
            if (skid_valid) begin
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                // Drain to a bubble; data is left as-is.
                main_valid <= 1'b0;
                main_ctrl  <= NOP_CTRL;
            end
        end
    end
`else
    assign in_ready = out_ready || !main_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= NOP_CTRL;
            main_data  <= '0;
        end else if (accept) begin
            // Covers both "empty" and "emit with replacement".
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
        end else if (emit) begin
            main_valid <= 1'b0;
            main_ctrl  <= NOP_CTRL;
        end
    end
`endif

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (main_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 80;
  localparam int SW = 4;
  localparam logic [CW-1:0] NOP = '0;
  localparam int SAT = (1 << SW) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [SW-1:0] stall_cnt;

  pipe_stage_reg #(
    .CTRL_W      (CW),
    .DATA_W      (DW),
    .NOP_CTRL    (NOP),
    .STALL_CNT_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: the stage is modelled as a FIFO of capacity CAP
  logic [CW+DW-1:0] exp_q[$];
  logic [DW-1:0]    idle_data = '0;
  int               stall_exp = 0;
  int               tests = 0;
  int               fails = 0;
  logic             checking = 1'b0;

  // pending upstream item
  logic          pend_v = 1'b0;
  logic [CW-1:0] pend_c = '0;
  logic [DW-1:0] pend_d = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares against the FIFO model once per cycle, away from the edge
  always @(negedge clk) begin
    if (checking) begin
      int occ;
      logic exp_ir;
      occ = exp_q.size();
      chk("out_valid", 128'(out_valid), 128'(occ > 0));
      if (CAP == 2) exp_ir = (occ < 2);
      else          exp_ir = out_ready || (occ == 0);
      chk("in_ready", 128'(in_ready), 128'(exp_ir));
      chk("stall_cnt", 128'(stall_cnt), 128'(stall_exp));
      if (occ == 0) begin
        chk("idle_ctrl", 128'(out_ctrl), 128'(NOP));
        chk("idle_data", 128'(out_data), 128'(idle_data));
      end else begin
        chk("out_ctrl", 128'(out_ctrl), 128'(exp_q[0][CW+DW-1:DW]));
        chk("out_data", 128'(out_data), 128'(exp_q[0][DW-1:0]));
      end
      // model update for the coming edge
      if (rst || flush) begin
        exp_q.delete();
        idle_data = '0;
      end else if (occ > 0 && out_ready) begin
        idle_data = exp_q[0][DW-1:0];
        void'(exp_q.pop_front());
      end
      if (rst) stall_exp = 0;
      else if (occ > 0 && !out_ready && stall_exp < SAT) stall_exp++;
    end
  end

  // driver tasks
  task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d);
    pend_v = 1'b1;
    pend_c = c;
    pend_d = d;
  endtask

  task automatic cycle(input logic ordy, input logic fl, input logic r);
    logic acc;
    logic [CW+DW-1:0] ent;
    @(posedge clk); #1;
    in_valid  = pend_v;
    in_ctrl   = pend_c;
    in_data   = pend_d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    acc = pend_v && in_ready && !fl && !r;
    ent = {pend_c, pend_d};
    if (pend_v && (acc || fl || r)) pend_v = 1'b0;
    if (acc) begin
      #1;
      exp_q.push_back(ent);
    end
  endtask

  task automatic wait_taken(input logic ordy);
    for (int k = 0; k < 20 && pend_v; k++) cycle(ordy, 1'b0, 1'b0);
    if (pend_v) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=%0b expected acceptance within 20 cycles", in_ready);
      pend_v = 1'b0;
    end
  endtask

  task automatic rand_data(output logic [DW-1:0] d);
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    d = t[DW-1:0];
  endtask

  initial begin
    logic [DW-1:0] rd;
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_stall", 128'(stall_cnt), 128'(0));

    // stream 1..4 at full rate
    for (int i = 1; i <= 4; i++) begin
      offer(CW'(i), DW'(i));
      wait_taken(1'b1);
    end
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    chk("stream_drain_data", 128'(out_data), 128'(4));

    // stall for 5 cycles with a second entry offered
    offer(8'h11, DW'(80'h11));
    wait_taken(1'b0);
    offer(8'h22, DW'(80'h22));
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    chk("skid_in_ready_low", 128'(in_ready), 128'(0));
`endif
    chk("stall_hold_data", 128'(out_data), 128'(80'h11));
    cycle(1'b1, 1'b0, 1'b0);
    chk("stall_cnt_5", 128'(stall_cnt), 128'(5));
    wait_taken(1'b1);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);

    // flush with 0xAA held and 0xBB offered
    offer(8'hAA, DW'(80'hAA));
    wait_taken(1'b0);
    offer(8'hBB, DW'(80'hBB));
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_out_ctrl", 128'(out_ctrl), 128'(NOP));
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // saturation, survival across flush, clear by rst
    offer(8'h05, DW'(80'h05));
    wait_taken(1'b0);
    repeat (21) cycle(1'b0, 1'b0, 1'b0);
    chk("stall_sat", 128'(stall_cnt), 128'(SAT));
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("stall_after_flush", 128'(stall_cnt), 128'(SAT));
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("stall_after_rst", 128'(stall_cnt), 128'(0));

    // reset mid-stream with the stage full
    offer(8'h61, DW'(80'h61));
    wait_taken(1'b0);
    offer(8'h62, DW'(80'h62));
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
    chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
    chk("rst_mid_data", 128'(out_data), 128'(0));
    for (int i = 0; i < 4; i++) begin
      offer(CW'(8'h71 + i), DW'(80'h71 + i));
      wait_taken(1'b1);
    end
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!pend_v && $urandom_range(0, 2) != 0) begin
        rand_data(rd);
        offer(CW'($urandom), rd);
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 1'b0);
    end
    wait_taken(1'b1);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    chk("final_out_valid", 128'(out_valid), 128'(0));

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
